// File: rtl/comp_1b_if.sv
// comp_1b_if: operand/result bundle for the registered magnitude comparator.
//   a, b         operands, WIDTH bits each
//   in_valid     operands valid; a comparison is captured on this edge
//   signed_mode  0 = unsigned, 1 = two's-complement (sampled with in_valid)
//   clr          synchronous clear of the event counters
//   aeb/agb/alb  registered one-hot result (equal / greater / less)
//   out_valid    result registers were updated on the previous edge
//   cnt_eq/gt/lt saturating result event counters, CNT_W bits each
// master drives operands and reads results; slave is the comparator side.
interface comp_1b_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             signed_mode;
    logic             clr;
    logic             aeb;
    logic             agb;
    logic             alb;
    logic             out_valid;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_lt;

    modport master (
        output a, b, in_valid, signed_mode, clr,
        input  aeb, agb, alb, out_valid, cnt_eq, cnt_gt, cnt_lt
    );

    modport slave (
        input  a, b, in_valid, signed_mode, clr,
        output aeb, agb, alb, out_valid, cnt_eq, cnt_gt, cnt_lt
    );
endinterface

// File: rtl/comp_1b.sv
// comp_1b: registered comparator with unsigned/signed modes and saturating
// per-result event counters.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears results, out_valid, counters
//   bus    comp_1b_if.slave: operands, mode, clear in; results, counters out
// All outputs come straight from flops, so there is no input-to-output
// combinational path. Results hold while in_valid is low.
module comp_1b #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    comp_1b_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             is_eq;
    logic             is_gt;
    logic             is_lt;

    logic             aeb_q;
    logic             agb_q;
    logic             alb_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_eq_q;
    logic [CNT_W-1:0] cnt_gt_q;
    logic [CNT_W-1:0] cnt_lt_q;

    // Inverting the sign bit maps two's-complement order onto unsigned
    // order, so a single unsigned comparator serves both modes. Equality is
    // taken on the raw operands and is unaffected by the mode.
    always_comb begin
        sign_mask = WIDTH'(bus.signed_mode) << (WIDTH - 1);
        a_key     = bus.a ^ sign_mask;
        b_key     = bus.b ^ sign_mask;
        is_eq     = (bus.a == bus.b);
        is_gt     = (a_key > b_key);
        is_lt     = (a_key < b_key);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aeb_q       <= 1'b0;
            agb_q       <= 1'b0;
            alb_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_eq_q    <= '0;
            cnt_gt_q    <= '0;
            cnt_lt_q    <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                aeb_q <= is_eq;
                agb_q <= is_gt;
                alb_q <= is_lt;
            end
            // clr wins over a simultaneous capture: the result is still
            // registered above, but it is not counted.
            if (bus.clr) begin
                cnt_eq_q <= '0;
                cnt_gt_q <= '0;
                cnt_lt_q <= '0;
            end else if (bus.in_valid) begin
                if (is_eq && cnt_eq_q != CNT_MAX) cnt_eq_q <= cnt_eq_q + CNT_W'(1);
                if (is_gt && cnt_gt_q != CNT_MAX) cnt_gt_q <= cnt_gt_q + CNT_W'(1);
                if (is_lt && cnt_lt_q != CNT_MAX) cnt_lt_q <= cnt_lt_q + CNT_W'(1);
            end
        end
    end

    assign bus.aeb       = aeb_q;
    assign bus.agb       = agb_q;
    assign bus.alb       = alb_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cnt_eq    = cnt_eq_q;
    assign bus.cnt_gt    = cnt_gt_q;
    assign bus.cnt_lt    = cnt_lt_q;

endmodule

// File: tb/tb_comp_1b.sv
// tb_comp_1b: self-checking bench for comp_1b (WIDTH=2, CNT_W=8).
// Directed cases, an exhaustive operand sweep in both modes, saturation,
// clear priority, asynchronous reset and a randomized run, all compared
// against an integer-arithmetic reference model.
module tb_comp_1b;

    localparam int WIDTH = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_aeb, m_agb, m_alb, m_ov, m_captured;
    int m_eq, m_gt, m_lt;

    comp_1b_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    comp_1b #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int toInt(logic [WIDTH-1:0] v, bit sm);
        if (sm && v[WIDTH-1]) return int'(v) - (1 << WIDTH);
        return int'(v);
    endfunction

    task automatic checkOutput(string tag, int obs, int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_aeb = 0; m_agb = 0; m_alb = 0; m_ov = 0; m_captured = 0;
        m_eq = 0; m_gt = 0; m_lt = 0;
    endtask

    task automatic modelStep(logic [WIDTH-1:0] ia, logic [WIDTH-1:0] ib,
                             bit sm, bit v, bit c);
        int x, y;
        m_ov = v;
        if (v) begin
            x = toInt(ia, sm);
            y = toInt(ib, sm);
            m_aeb = (x == y);
            m_agb = (x > y);
            m_alb = (x < y);
            m_captured = 1;
        end
        if (c) begin
            m_eq = 0; m_gt = 0; m_lt = 0;
        end else if (v) begin
            if (m_aeb && m_eq < CMAX) m_eq++;
            if (m_agb && m_gt < CMAX) m_gt++;
            if (m_alb && m_lt < CMAX) m_lt++;
        end
    endtask

    task automatic checkAll(string tag);
        checkOutput({tag, ".aeb"}, int'(bus.aeb), int'(m_aeb));
        checkOutput({tag, ".agb"}, int'(bus.agb), int'(m_agb));
        checkOutput({tag, ".alb"}, int'(bus.alb), int'(m_alb));
        checkOutput({tag, ".out_valid"}, int'(bus.out_valid), int'(m_ov));
        checkOutput({tag, ".cnt_eq"}, int'(bus.cnt_eq), m_eq);
        checkOutput({tag, ".cnt_gt"}, int'(bus.cnt_gt), m_gt);
        checkOutput({tag, ".cnt_lt"}, int'(bus.cnt_lt), m_lt);
        if (m_captured)
            checkOutput({tag, ".onehot"}, $countones({bus.aeb, bus.agb, bus.alb}), 1);
    endtask

    // Drive inputs on the falling edge, let the DUT capture on the rising
    // edge, then compare just after it.
    task automatic applyStimulus(string tag, logic [WIDTH-1:0] ia,
                                 logic [WIDTH-1:0] ib, bit sm, bit v, bit c);
        @(negedge clk);
        bus.a = ia;
        bus.b = ib;
        bus.signed_mode = sm;
        bus.in_valid = v;
        bus.clr = c;
        @(posedge clk);
        modelStep(ia, ib, sm, v, c);
        #1;
        checkAll(tag);
    endtask

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        modelReset();

        // Reset asserted before the first clock edge
        #1 rst_n = 1'b0;
        #2;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands straight after reset
        applyStimulus("eq00", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("eq00.aeb_direct", int'(bus.aeb), 1);
        checkOutput("eq00.cnt_eq_direct", int'(bus.cnt_eq), 1);

        // 3 vs 0 unsigned, then -1 vs 0 signed
        applyStimulus("u11_00", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("u11_00.agb_direct", int'(bus.agb), 1);
        applyStimulus("s11_00", 2'b11, 2'b00, 1'b1, 1'b1, 1'b0);
        checkOutput("s11_00.alb_direct", int'(bus.alb), 1);

        // 1 vs 2 unsigned, then 1 vs -2 signed, then hold
        applyStimulus("u01_10", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
        checkOutput("u01_10.alb_direct", int'(bus.alb), 1);
        applyStimulus("s01_10", 2'b01, 2'b10, 1'b1, 1'b1, 1'b0);
        checkOutput("s01_10.agb_direct", int'(bus.agb), 1);
        applyStimulus("hold", 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("hold.agb_direct", int'(bus.agb), 1);
        checkOutput("hold.out_valid_direct", int'(bus.out_valid), 0);

        // Exhaustive sweep, both modes
        for (int sm = 0; sm < 2; sm++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    applyStimulus($sformatf("sweep_m%0d_a%0d_b%0d", sm, i, j),
                                  2'(i), 2'(j), 1'(sm), 1'b1, 1'b0);

        // Saturation of the equal counter
        for (int n = 0; n < 300; n++)
            applyStimulus("sat", 2'(n % 4), 2'(n % 4), 1'(n % 2), 1'b1, 1'b0);
        checkOutput("sat.cnt_eq_direct", int'(bus.cnt_eq), CMAX);

        // Clear together with a capture: result updates, nothing counted
        applyStimulus("clr_cap", 2'b10, 2'b01, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_cap.agb_direct", int'(bus.agb), 1);
        checkOutput("clr_cap.cnt_eq_direct", int'(bus.cnt_eq), 0);
        checkOutput("clr_cap.cnt_gt_direct", int'(bus.cnt_gt), 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++)
            applyStimulus("rand", 2'($urandom), 2'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));

        // Asynchronous reset between edges with a capture pending
        applyStimulus("pre_rst", 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.a = 2'b00;
        bus.b = 2'b00;
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge clk);
        #1;
        checkAll("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        // First capture after reset release is a normal result
        applyStimulus("post_rst", 2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
        applyStimulus("post_rst_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
